// File: rtl/game_stats_counter.sv
// Score, lines and level statistics in BCD, updated from line-clear events.
// Points are base x (level+1), accumulated one BCD add per cycle.
module game_stats_counter #(
    parameter int NUMBER_LEN      = 6,
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 99
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    new_game_i,
    input  logic                    lines_valid_i,
    input  logic [2:0]              lines_cnt_i,
    output logic                    lines_ready_o,
    output logic [NUMBER_LEN*4-1:0] score_o,
    output logic [NUMBER_LEN*4-1:0] lines_o,
    output logic [NUMBER_LEN*4-1:0] level_o
);

    localparam int W = NUMBER_LEN * 4;

    // state       | meaning
    // S_IDLE      | waiting for a line-clear event, ready high
    // S_ADD_LINES | add latched count to lines, maybe step level
    // S_ADD_SCORE | add base points once per iteration
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ADD_LINES = 2'd1;
    localparam logic [1:0] S_ADD_SCORE = 2'd2;

    // Level stepping watches the tens digit, so only 10 lines per level works.
    if (LINES_PER_LEVEL != 10) begin : g_bad_lpl
        $error("LINES_PER_LEVEL must be 10");
    end

    localparam logic [W-1:0] ALL_NINES = {NUMBER_LEN{4'h9}};

    function automatic logic [W:0] bcd_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [4:0]   s;
        logic         c;
        logic [W-1:0] r;
        c = 1'b0;
        r = '0;
        for (int i = 0; i < NUMBER_LEN; i++) begin
            s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
            if (s > 5'd9) begin
                s = s + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*i +: 4] = s[3:0];
        end
        return {c, r};
    endfunction

    logic [1:0]   state_q;
    logic [2:0]   cnt_q;
    logic [6:0]   lvl_q;
    logic [6:0]   iter_q;

    logic [W-1:0] base;
    logic [W-1:0] lines_inc;
    logic [W-1:0] one;
    logic [W:0]   lines_sum;
    logic [W:0]   score_sum;
    logic [W:0]   level_sum;
    logic [W-1:0] lines_next;
    logic [W-1:0] score_next;
    logic [6:0]   level_bin;
    logic         legal;

    assign lines_ready_o = (state_q == S_IDLE);
    assign level_bin     = ({3'b0, level_o[7:4]} * 7'd10) + {3'b0, level_o[3:0]};

    always_comb begin
        base  = '0;
        legal = 1'b1;
        case (cnt_q)
            3'd1:    base[15:0] = 16'h0040;
            3'd2:    base[15:0] = 16'h0100;
            3'd3:    base[15:0] = 16'h0300;
            3'd4:    base[15:0] = 16'h1200;
            default: legal = 1'b0;
        endcase
        lines_inc      = '0;
        lines_inc[3:0] = {1'b0, cnt_q};
        one            = '0;
        one[0]         = 1'b1;
        lines_sum      = bcd_add(lines_o, lines_inc);
        score_sum      = bcd_add(score_o, base);
        level_sum      = bcd_add(level_o, one);
        lines_next     = lines_sum[W] ? ALL_NINES : lines_sum[W-1:0];
        score_next     = score_sum[W] ? ALL_NINES : score_sum[W-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lvl_q   <= '0;
            iter_q  <= '0;
            score_o <= '0;
            lines_o <= '0;
            level_o <= '0;
        end else if (new_game_i) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            score_o <= '0;
            lines_o <= '0;
            level_o <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (lines_valid_i) begin
                        cnt_q   <= lines_cnt_i;
                        lvl_q   <= level_bin;
                        state_q <= S_ADD_LINES;
                    end
                end
                S_ADD_LINES: begin
                    if (legal) begin
                        lines_o <= lines_next;
                        if ((lines_next[7:4] != lines_o[7:4]) && (level_bin < 7'(MAX_LEVEL)))
                            level_o <= level_sum[W-1:0];
                        iter_q  <= lvl_q + 7'd1;
                        state_q <= S_ADD_SCORE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ADD_SCORE: begin
                    score_o <= score_next;
                    iter_q  <= iter_q - 7'd1;
                    if (iter_q == 7'd1)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_stats_counter.sv
// Scoreboard bench for game_stats_counter: the driver pushes expected results,
// a negedge monitor pops them when lines_ready_o returns high.
module tb_game_stats_counter;

    logic        clk;
    logic        rst;
    logic        new_game;
    logic        valid;
    logic [2:0]  cnt;
    logic        ready;
    logic [23:0] score;
    logic [23:0] lines;
    logic [23:0] level;

    game_stats_counter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .new_game_i   (new_game),
        .lines_valid_i(valid),
        .lines_cnt_i  (cnt),
        .lines_ready_o(ready),
        .score_o      (score),
        .lines_o      (lines),
        .level_o      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] s;
        logic [23:0] l;
        logic [23:0] v;
        int          busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   busy  = 0;

    int m_score = 0;
    int m_lines = 0;
    int m_level = 0;

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int          t;
        t = v;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy = 0;
        end else if (!ready) begin
            busy++;
        end else if (busy > 0) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_completion: got busy %0d expected no event", busy);
            end else begin
                e = exp_q.pop_front();
                chk("score", score, e.s);
                chk("lines", lines, e.l);
                chk("level", level, e.v);
                chk("busy_cycles", 24'(busy), 24'(e.busy));
            end
            busy = 0;
        end
    end

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL ready_timeout: got ready 0 expected 1");
        end
    endtask

    task automatic model_clear();
        m_score = 0;
        m_lines = 0;
        m_level = 0;
    endtask

    task automatic send(input logic [2:0] c);
        exp_t e;
        int   base;
        int   old;
        int   pre_level;
        wait_ready();
        pre_level = m_level;
        case (c)
            3'd1:    base = 40;
            3'd2:    base = 100;
            3'd3:    base = 300;
            3'd4:    base = 1200;
            default: base = 0;
        endcase
        if (base != 0) begin
            old = m_lines;
            m_lines = (old + int'(c) > 999999) ? 999999 : old + int'(c);
            if (((old / 10) % 10) != ((m_lines / 10) % 10) && m_level < 99)
                m_level++;
            m_score = (m_score + base * (pre_level + 1) > 999999) ? 999999
                                                                  : m_score + base * (pre_level + 1);
            e.busy = pre_level + 2;
        end else begin
            e.busy = 1;
        end
        e.s = to_bcd(m_score);
        e.l = to_bcd(m_lines);
        e.v = to_bcd(m_level);
        exp_q.push_back(e);
        valid = 1'b1;
        cnt   = c;
        @(posedge clk);
        #1 valid = 1'b0;
        wait_ready();
    endtask

    task automatic new_game_pulse();
        wait_ready();
        new_game = 1'b1;
        @(posedge clk);
        #1 new_game = 1'b0;
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   extra;
        rst = 1'b1; new_game = 1'b0; valid = 1'b0; cnt = '0;
        repeat (3) @(negedge clk);
        chk("reset_score", score, 24'h0);
        chk("reset_lines", lines, 24'h0);
        chk("reset_level", level, 24'h0);
        chk("reset_ready", 24'(ready), 24'h1);
        rst = 1'b0;

        // first single at level 0: 40 points, 2 busy cycles
        send(3'd1);
        new_game_pulse();
        send(3'd4);
        send(3'd2);
        send(3'd2);
        send(3'd2);
        send(3'd1);
        send(3'd0);
        send(3'd7);
        send(3'd3);

        // valid together with new_game while idle is dropped
        wait_ready();
        new_game = 1'b1; valid = 1'b1; cnt = 3'd4;
        @(posedge clk);
        #1 begin new_game = 1'b0; valid = 1'b0; end
        model_clear();
        @(negedge clk);
        chk("ng_drop_ready", 24'(ready), 24'h1);
        chk("ng_drop_lines", lines, 24'h0);
        chk("ng_drop_score", score, 24'h0);

        // climb to level 5, then abort during ADD_SCORE
        for (int i = 0; i < 30 && m_level < 5; i++) send(3'd4);
        chk("level5", level, 24'h5);
        wait_ready();
        e.s = 24'h0; e.l = 24'h0; e.v = 24'h0; e.busy = 2;
        exp_q.push_back(e);
        valid = 1'b1; cnt = 3'd1;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        new_game = 1'b1; valid = 1'b1;
        @(posedge clk);
        #1 begin new_game = 1'b0; valid = 1'b0; end
        model_clear();
        @(negedge clk);
        chk("abort_ready", 24'(ready), 24'h1);
        chk("abort_level", level, 24'h0);

        // score saturation: tetrises until 999999, then more keep it there
        extra = 0;
        for (int i = 0; i < 200 && extra < 2; i++) begin
            send(3'd4);
            if (m_score == 999999) extra++;
        end
        chk("sat_score", score, 24'h999999);

        // asynchronous reset in the middle of ADD_SCORE
        new_game_pulse();
        send(3'd4); send(3'd4); send(3'd4);
        wait_ready();
        valid = 1'b1; cnt = 3'd1;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_score", score, 24'h0);
        chk("rst_mid_lines", lines, 24'h0);
        chk("rst_mid_level", level, 24'h0);
        chk("rst_mid_ready", 24'(ready), 24'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);

        chk("queue_empty", 24'(exp_q.size()), 24'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
